// File: rtl/stack_mem_pkg.sv
// Shared types and constants for the stack CPU memory arbiter and its datapath.
package stack_mem_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
module rr_arbiter2
    import stack_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       any,
    output logic       winner
);

    always_comb begin
        any    = |req;
        winner = PORT_CPU;
        case (req)
            2'b01:   winner = PORT_CPU;
            2'b10:   winner = PORT_LDR;
            2'b11:   winner = ~last_owner;
            default: winner = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/stack_mem_arbiter.sv
// Shares the single-port unified memory of the stack CPU between the CPU (port 0)
// and the loader/debug path (port 1), one fixed-latency transaction at a time.
module stack_mem_arbiter
    import stack_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_done,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_done,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
            $error("stack_mem_arbiter: MEM_LAT must lie in 1..4 (3-bit latency counter)");
        end
    endgenerate

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] rbuf_q, rbuf_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] l_rdata_q, l_rdata_d;

    logic arb_any;
    logic arb_winner;

    rr_arbiter2 u_rr (
        .req        ({l_req, c_req}),
        .last_owner (owner_q),
        .any        (arb_any),
        .winner     (arb_winner)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no branch can leave a latch behind.
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rbuf_d    = rbuf_q;
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    owner_d = arb_winner;
                    we_d    = (arb_winner == PORT_LDR) ? l_we    : c_we;
                    addr_d  = (arb_winner == PORT_LDR) ? l_addr  : c_addr;
                    wdata_d = (arb_winner == PORT_LDR) ? l_wdata : c_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d   = LAT_INIT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Count 1 marks the cycle the memory presents read data.
                if (cnt_q == 3'd1) begin
                    if (!we_q) begin
                        rbuf_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!we_q) begin
                    if (owner_q == PORT_LDR) begin
                        l_rdata_d = rbuf_q;
                    end else begin
                        c_rdata_d = rbuf_q;
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= PORT_LDR;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rbuf_q    <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rbuf_q    <= rbuf_d;
            c_rdata_q <= c_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    logic in_access;
    logic in_resp;
    logic rd_resp;

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);
    assign rd_resp   = in_resp && !we_q;

    assign c_gnt     = in_access && (owner_q == PORT_CPU);
    assign l_gnt     = in_access && (owner_q == PORT_LDR);
    assign c_done    = in_resp && (owner_q == PORT_CPU);
    assign l_done    = in_resp && (owner_q == PORT_LDR);

    // Read data is forwarded from the buffer during RESP so it is valid alongside done.
    assign c_rdata   = (rd_resp && owner_q == PORT_CPU) ? rbuf_q : c_rdata_q;
    assign l_rdata   = (rd_resp && owner_q == PORT_LDR) ? rbuf_q : l_rdata_q;

    assign mem_en    = in_access;
    assign mem_we    = in_access && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;

endmodule

// File: doc/stack_mem_arbiter.md
Name: stack_mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multicycle stack CPU between two requesters.
- Port 0 is the CPU controller path: fetch, load for push, store for pop.
- Port 1 is the program loader/debug path.
- Round-robin arbitration, one transaction at a time; per-port req/gnt/done handshake with a fixed-latency memory behind it.

Parameters:
- AW, 5, memory address width.
- DW, 8, data width.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- c_req  in  1  CPU request; held until c_gnt
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_gnt  out  1  one-cycle pulse: CPU request accepted
- c_done  out  1  one-cycle pulse: CPU transaction complete
- c_rdata  out  DW  CPU read data; valid from c_done onward, held until the next CPU read completes
- l_req, l_we, l_addr, l_wdata, l_gnt, l_done, l_rdata: same as the c_* ports, for the loader port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high whenever state is not IDLE
- owner  out  1  port of the current or last transaction (0 = CPU, 1 = loader)

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, RESP. All outputs are registered or decoded from state plus registers; there is no combinational req-to-gnt path.
- Reset (async):
  - state=IDLE; all gnt, done, mem_en and mem_we outputs = 0.
  - mem_addr=0, mem_wdata=0, c_rdata=0, l_rdata=0.
  - last_owner=1, so the CPU wins the first tie; owner=1.
- IDLE: samples both req inputs every cycle.
  - Neither req: stay in IDLE.
  - Exactly one req: that port wins.
  - Both req: the winner is the port other than last_owner.
  - On a win: latch the winner's we, addr and wdata; set owner=last_owner=winner; go to ACCESS.
- ACCESS (exactly one cycle):
  - gnt of the winner = 1; mem_en = 1; mem_we = latched we; mem_addr/mem_wdata = latched values.
  - Load the latency counter with MEM_LAT; go to WAIT.
- WAIT:
  - Decrement the counter each cycle; mem_en = 0.
  - In the cycle where the counter reaches 1, capture mem_rdata into an internal buffer (reads only), then go to RESP.
  - WAIT therefore lasts exactly MEM_LAT cycles.
- RESP (one cycle):
  - done of the owner = 1.
  - On a read, the owner's rdata register takes the buffered value. On a write, rdata is unchanged.
  - Next state is IDLE.
- Latency: req first sampled in IDLE at cycle 0 → gnt and mem_en at cycle 1 → done at cycle 2+MEM_LAT. Back-to-back throughput is one transaction per MEM_LAT+3 cycles.
- Withdrawal: req dropped before gnt means the request is forgotten; arbitration re-evaluates each IDLE cycle.
- Req dropped, or addr/wdata changed, after gnt: no effect; the transaction completes from latched values.
- Req still high in the IDLE cycle after done: treated as a new request.
- Starvation-free: with both ports requesting continuously, grants strictly alternate.
- The counter is sized for MEM_LAT ≤ 4 (3 bits). MEM_LAT outside 1..4 is a configuration error and must be flagged by an elaboration-time check.
- Reset asserted mid-transaction: immediate return to IDLE with reset values. The pending done is never issued, and the requester must reissue the request.

Decomposition:
- Package stack_mem_pkg:
  - state encoding (IDLE=0, ACCESS=1, WAIT=2, RESP=3)
  - port ids (PORT_CPU=0, PORT_LDR=1)
  - default AW/DW constants shared with the CPU datapath
- One sub-module, rr_arbiter2:
  - combinational two-way round-robin pick
  - inputs: req[1:0], last_owner
  - outputs: any, winner

Test Plan:
1. MEM_LAT=1. Loader preloads 0xA5 at addr 3: l_req/l_we=1 at cycle 0 → l_gnt at cycle 1 with mem_en=1, mem_we=1, mem_addr=3, mem_wdata=0xA5; l_done at cycle 3; c_* outputs stay 0.
2. CPU read of addr 3 after test 1 → c_gnt at cycle 1, c_done at cycle 3, c_rdata=0xA5; l_rdata unchanged.
3. c_req and l_req both asserted at cycle 0 after reset → CPU granted first. Holding both reqs produces grant order CPU, LDR, CPU, LDR, with each done MEM_LAT+3 cycles apart.
4. MEM_LAT=3, CPU read of addr 7 holding 0x3C; c_addr changed to 9 after c_gnt → mem_addr=7, c_done at cycle 5, c_rdata=0x3C.
5. rst pulsed in the WAIT state of a CPU read → busy=0, no c_done, c_rdata=0. A reissued request completes normally with the CPU winning a tie.
6. l_req pulsed for one IDLE cycle, then dropped, while CPU idle → transaction still granted (it was sampled). A req raised and dropped while busy leaves no pending grant.
